// File: rtl/demux_1x8_deser_if.sv
// Bus bundle for the 1:8 serial deserializer: serial input side plus the
// parallel word, lane select and status outputs.
interface demux_1x8_deser_if;
    logic       din;
    logic       din_valid;
    logic       start;
    logic [7:0] dout;
    logic       dout_valid;
    logic [2:0] sel;
    logic       busy;
    logic       frame_err;

    // Source of the serial stream / consumer of the rebuilt word.
    modport master (
        output din, din_valid, start,
        input  dout, dout_valid, sel, busy, frame_err
    );

    // The deserializer itself.
    modport slave (
        input  din, din_valid, start,
        output dout, dout_valid, sel, busy, frame_err
    );
endinterface

// File: rtl/demux_1x8_deser.sv
// Serial-to-parallel 1:8 demultiplexer. A 3-bit lane counter steers each
// accepted bit into a shadow register; the eighth bit completes the frame,
// which is published on dout with a one-cycle dout_valid strobe. Restarts
// mid-frame and idle timeouts abort the frame with a one-cycle frame_err.
module demux_1x8_deser #(
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst,
    demux_1x8_deser_if.slave  bus
);
    // Wide enough to count up to TIMEOUT; kept at least 1 bit when disabled.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RECV} state_e;

    state_e        state_q, state_d;
    logic [7:0]    shadow_q, shadow_d;
    logic [7:0]    dout_q, dout_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic          dv_q, dv_d;
    logic          fe_q, fe_d;

    // State register and all datapath flops, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= 8'h00;
            dout_q   <= 8'h00;
            cnt_q    <= 3'd0;
            to_q     <= '0;
            dv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            dv_q     <= dv_d;
            fe_q     <= fe_d;
        end
    end

    // Next state: restart beats bit accept, which beats timeout.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        to_d     = to_q;
        dv_d     = 1'b0;
        fe_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // Bits without start are dropped silently while idle.
                if (bus.din_valid && bus.start) begin
                    shadow_d[0] = bus.din;
                    cnt_d       = 3'd1;
                    to_d        = '0;
                    state_d     = RECV;
                end
            end
            RECV: begin
                if (bus.din_valid && bus.start) begin
                    fe_d        = 1'b1;
                    shadow_d[0] = bus.din;
                    cnt_d       = 3'd1;
                    to_d        = '0;
                end else if (bus.din_valid) begin
                    shadow_d[cnt_q] = bus.din;
                    to_d            = '0;
                    cnt_d           = cnt_q + 3'd1;   // 7 wraps to 0
                    if (cnt_q == 3'd7) begin
                        dout_d  = {bus.din, shadow_q[6:0]};
                        dv_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else if (TIMEOUT != 0) begin
                    // This idle cycle is the TIMEOUT-th in a row: abort.
                    if (int'(to_q) == TIMEOUT - 1) begin
                        fe_d    = 1'b1;
                        cnt_d   = 3'd0;
                        to_d    = '0;
                        state_d = IDLE;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.frame_err  = fe_q;
    assign bus.sel        = cnt_q;
    assign bus.busy       = (state_q == RECV);
endmodule

// File: tb/tb_demux_1x8_deser.sv
// Self-checking bench for demux_1x8_deser: directed scenarios followed by
// randomized traffic, all compared every cycle against a frame-level model
// that just collects accepted bits in a queue.
module tb_demux_1x8_deser;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;

    demux_1x8_deser_if bus();

    demux_1x8_deser #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // ---- behavioural model: bits of the frame in progress, idle run length
    logic       frame_q[$];
    int         idle_n;
    logic [7:0] exp_dout;
    logic       exp_dv, exp_fe;

    task automatic model_reset();
        frame_q.delete();
        idle_n   = 0;
        exp_dout = 8'h00;
        exp_dv   = 1'b0;
        exp_fe   = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic d);
        exp_dv = 1'b0;
        exp_fe = 1'b0;
        if (rst) begin
            model_reset();
        end else if (v && s) begin
            if (frame_q.size() > 0) exp_fe = 1'b1;
            frame_q.delete();
            frame_q.push_back(d);
            idle_n = 0;
        end else if (v && frame_q.size() > 0) begin
            frame_q.push_back(d);
            idle_n = 0;
            if (frame_q.size() == 8) begin
                for (int k = 0; k < 8; k++) exp_dout[k] = frame_q[k];
                exp_dv = 1'b1;
                frame_q.delete();
            end
        end else if (!v && frame_q.size() > 0) begin
            idle_n++;
            if (TO != 0 && idle_n == TO) begin
                exp_fe = 1'b1;
                frame_q.delete();
                idle_n = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---- compare process: DUT against model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout",       bus.dout,              exp_dout);
            chk("dout_valid", {7'd0, bus.dout_valid}, {7'd0, exp_dv});
            chk("frame_err",  {7'd0, bus.frame_err},  {7'd0, exp_fe});
            chk("sel",        {5'd0, bus.sel},        8'(frame_q.size()));
            chk("busy",       {7'd0, bus.busy},       {7'd0, (frame_q.size() > 0)});
        end
    end

    // One clock of stimulus; inputs change only on falling edges.
    task automatic step(input logic v, input logic s, input logic d);
        bus.din_valid = v;
        bus.start     = s;
        bus.din       = d;
        @(posedge clk);
        model_step(v, s, d);
        @(negedge clk);
        cyc++;
    endtask

    task automatic rnd_step();
        step(1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Asynchronous reset asserted mid-cycle, checked before the next edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_dout", bus.dout, 8'h00);
        chk("async_rst_sel",  {5'd0, bus.sel}, 8'h00);
        chk("async_rst_busy", {7'd0, bus.busy}, 8'h00);
        @(negedge clk);
        rnd_step();
        rnd_step();
        rst = 1'b0;
    endtask

    int fe_cnt;
    int t1, t2;
    logic [7:0] b;

    initial begin
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.start = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        // Reset held with random inputs.
        repeat (4) rnd_step();
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_sel",  {5'd0, bus.sel}, 8'h00);
        chk("rst_busy", {7'd0, bus.busy}, 8'h00);
        rst = 1'b0;
        step(0, 0, 0);

        // 8'hA5, LSB first, no gaps.
        b = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            step(1, k == 0, b[k]);
            chk("a5_sel", {5'd0, bus.sel}, (k < 7) ? 8'(k + 1) : 8'h00);
        end
        chk("a5_dout", bus.dout, 8'hA5);
        chk("a5_dv",   {7'd0, bus.dout_valid}, 8'h01);
        step(0, 0, 0);
        chk("a5_dv_drop", {7'd0, bus.dout_valid}, 8'h00);

        // 8'h3C with 3 idle cycles between bits.
        b = 8'h3C;
        fe_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, k == 0, b[k]);
            if (bus.frame_err) fe_cnt++;
            if (k < 7) begin
                repeat (3) begin
                    step(0, 0, 0);
                    if (bus.frame_err) fe_cnt++;
                    chk("3c_busy", {7'd0, bus.busy}, 8'h01);
                end
            end
        end
        chk("3c_dout", bus.dout, 8'h3C);
        chk("3c_no_fe", 8'(fe_cnt), 8'h00);

        // 4 bits, then a restart carrying bit 1, then 7 zeros.
        step(1, 1, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
        step(1, 1, 1);
        chk("rs_fe",   {7'd0, bus.frame_err}, 8'h01);
        chk("rs_sel",  {5'd0, bus.sel}, 8'h01);
        chk("rs_dout", bus.dout, 8'h3C);
        for (int k = 0; k < 7; k++) step(1, 0, 0);
        chk("rs_dout_new", bus.dout, 8'h01);

        // 2 bits, then TO idle cycles -> abort on the TO-th.
        step(1, 1, 0); step(1, 0, 1);
        for (int i = 1; i <= TO; i++) begin
            step(0, 0, 0);
            if (i == TO - 1) chk("to_early_fe", {7'd0, bus.frame_err}, 8'h00);
        end
        chk("to_fe",   {7'd0, bus.frame_err}, 8'h01);
        chk("to_busy", {7'd0, bus.busy}, 8'h00);
        chk("to_sel",  {5'd0, bus.sel}, 8'h00);
        step(1, 0, 1);
        chk("to_bare_sel",  {5'd0, bus.sel}, 8'h00);
        chk("to_bare_busy", {7'd0, bus.busy}, 8'h00);

        // Reset after 5 bits, then 8'hFF.
        for (int k = 0; k < 5; k++) step(1, k == 0, 1);
        do_reset();
        fe_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, k == 0, 1);
            if (bus.frame_err) fe_cnt++;
            if (k < 7) chk("ff_hold", bus.dout, 8'h00);
        end
        chk("ff_dout", bus.dout, 8'hFF);
        chk("ff_no_fe", 8'(fe_cnt), 8'h00);

        // Back-to-back 8'h12 then 8'h34.
        t1 = -1; t2 = -1;
        for (int f = 0; f < 2; f++) begin
            b = (f == 0) ? 8'h12 : 8'h34;
            for (int k = 0; k < 8; k++) begin
                step(1, k == 0, b[k]);
                if (bus.dout_valid) begin
                    if (f == 0) t1 = cyc; else t2 = cyc;
                end
            end
            chk("b2b_dout", bus.dout, b);
        end
        chk("b2b_gap", 8'(t2 - t1), 8'd8);

        // Randomized traffic, with idle bursts and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 59) == 0) begin
                repeat ($urandom_range(10, 20)) step(0, 0, 1'($urandom));
            end else begin
                step(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), 1'($urandom));
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/demux_1x8_deser.md
# demux_1x8_deser

Serial-to-parallel demultiplexer: routes a 1-bit input stream onto eight output lanes in order, lane 0 first. An internal 3-bit lane counter acts as the select lines, so bit k of a frame lands on `dout[k]`. It is the receiving end of the 8:1 selector path. An 8-lane word selected with s2,s1,s0 counting 0..7 is rebuilt here and presented as one registered byte with a one-cycle valid strobe. It also reports framing and timeout errors.

## Interface
- `TIMEOUT`, default 16: idle cycles (no `din_valid`) tolerated mid-frame before abort; 0 disables the timeout.
- `clk` input 1: the block's only clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `din` input 1: serial data bit.
- `din_valid` input 1: `din` is sampled on this edge.
- `start` input 1: marks the current `din` as lane-0 bit of a new frame; only meaningful with `din_valid`=1.
- `dout` output 8: last completed word; `dout[k]` is frame bit k.
- `dout_valid` output 1: one-cycle pulse, `dout` was just updated.
- `sel` output 3: lane the next accepted bit will be written to (s2,s1,s0 equivalent).
- `busy` output 1: frame in progress.
- `frame_err` output 1: one-cycle pulse on an aborted frame.

## Operation
- Reset values: `dout`=8'h00, `dout_valid`=0, `sel`=0, `busy`=0, `frame_err`=0. The shadow register, counter and timeout counter are also cleared, and the state is IDLE.
- State machine has two states, IDLE and RECV. It is the only block state besides the shadow register, the lane counter and the timeout counter.
- IDLE:
  - `din_valid`=1 and `start`=1: write `din` to shadow[0], set counter to 1, go to RECV.
  - `din_valid`=1 and `start`=0: the bit is ignored and there is no error.
  - Otherwise: hold.
- RECV, `din_valid`=1 and `start`=0:
  - Write `din` to shadow[counter] and increment the counter.
  - If counter==7, the frame is complete. In that case:
    - `dout` loads {`din`, shadow[6:0]};
    - `dout_valid` pulses;
    - counter wraps to 0;
    - state returns to IDLE.
- RECV, `din_valid`=1 and `start`=1: restart.
  - Pulse `frame_err`.
  - Write `din` to shadow[0] and set counter to 1.
  - Stay in RECV.
  - `dout` is unchanged.
- RECV, `din_valid`=0:
  - Hold the counter and increment the timeout counter.
  - If the timeout counter reaches `TIMEOUT` (nonzero), pulse `frame_err`, clear the counter and go to IDLE.
  - The timeout counter clears on every accepted bit and on entry to RECV.
- Shadow lanes not yet written in a frame are don't-care; `dout` only ever changes on frame completion or reset.
- `sel` = counter value. `busy` = (state==RECV).
- Priority when events coincide in RECV: `rst` > start-restart > bit accept > timeout. A valid bit on the cycle timeout would fire is accepted, and there is no timeout.

## Timing
- The 8th bit is sampled at edge N. `dout` and `dout_valid`=1 are visible after edge N, and `dout_valid` drops after edge N+1 unless another frame completes.
- Back-to-back frames: `start`+`din_valid` on the cycle right after completion is accepted with no gap. Minimum frame period is 8 cycles.
- `frame_err` is high for exactly one cycle per abort, coincident with the restart or timeout edge.
- Timeout: with `TIMEOUT`=T, abort occurs on the T-th consecutive cycle with `din_valid`=0 in RECV.
- Reset asserted mid-frame clears all state immediately and asynchronously. No `dout_valid` or `frame_err` is emitted. The partial frame is lost.

## Test plan
- Reset: hold `rst` with random inputs. Outputs must equal the reset values above, `sel`=0, `busy`=0.
- Frame 8'hA5 sent LSB first on 8 consecutive cycles (bits 1,0,1,0,0,1,0,1; `start` with the first). Required: `dout`=8'hA5 with one `dout_valid` pulse on the 8th edge, and `sel` stepping 1..7 then 0.
- Frame 8'h3C with 3-cycle `din_valid` gaps between bits (TIMEOUT=16). Required: `dout`=8'h3C, `busy` high throughout, no `frame_err`.
- 4 bits of a frame, then `start` with bit 1. Required: one `frame_err` pulse, `sel`=1, and the next 7 bits 0 produce `dout`=8'h01. Earlier `dout` must be unchanged until then.
- 2 bits, then 16 idle cycles. Required: `frame_err` pulse on the 16th idle edge, `busy`=0, `sel`=0. A following bare `din_valid` without `start` is ignored.
- Reset mid-frame after 5 bits, then a full frame 8'hFF. Required: `dout` stays 8'h00 until 8'hFF completes, and no `frame_err`. Back-to-back 8'h12 then 8'h34 must give two `dout_valid` pulses 8 cycles apart.
